// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: channel mode encoding and max-count helper.
package counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    function automatic longint unsigned cnt_max(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/counter_cell.sv
// One counter channel: count and sticky overflow registers with clr > load > inc priority.
module counter_cell
    import counter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  mode_e            mode,
    input  logic             ovf_ack,
    output logic [WIDTH-1:0] cnt,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(cnt_max(WIDTH));

    logic [WIDTH:0] sum;
    logic           at_max;
    logic           ovf_event;

    // Carry out of the widened increment doubles as the max-detect.
    assign sum       = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
    assign at_max    = sum[WIDTH];
    assign ovf_event = !load && inc && at_max;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            if (load)
                cnt <= load_val;
            else if (inc && !at_max)
                cnt <= sum[WIDTH-1:0];
            else if (inc)
                cnt <= (mode == MODE_SAT) ? MAX : '0;
            // A same-cycle overflow event beats the acknowledge.
            ovf <= ovf_event || (ovf && !ovf_ack);
        end
    end

endmodule

// File: rtl/counter_bank.sv
// NCH independent event counters with sticky overflow flags and a coherent snapshot.
module counter_bank
    import counter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NCH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       inc,
    input  logic [NCH-1:0]       clr,
    input  logic [NCH-1:0]       load,
    input  logic [NCH*WIDTH-1:0] load_val,
    input  logic [NCH-1:0]       sat_mode,
    input  logic [NCH-1:0]       ovf_ack,
    input  logic                 snap,
    output logic [NCH*WIDTH-1:0] cnt,
    output logic [NCH-1:0]       ovf,
    output logic                 any_ovf,
    output logic [NCH*WIDTH-1:0] snap_cnt,
    output logic                 snap_valid
);

    genvar i;
    generate
        for (i = 0; i < NCH; i++) begin : g_ch
            counter_cell #(.WIDTH(WIDTH)) u_cell (
                .clk      (clk),
                .reset    (reset),
                .inc      (inc[i]),
                .clr      (clr[i]),
                .load     (load[i]),
                .load_val (load_val[i*WIDTH +: WIDTH]),
                .mode     (mode_e'(sat_mode[i])),
                .ovf_ack  (ovf_ack[i]),
                .cnt      (cnt[i*WIDTH +: WIDTH]),
                .ovf      (ovf[i])
            );
        end
    endgenerate

    assign any_ovf = |ovf;

    // Capturing the registered counts gives the pre-update value of every channel at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_cnt   <= '0;
            snap_valid <= 1'b0;
        end else begin
            snap_valid <= snap;
            if (snap)
                snap_cnt <= cnt;
        end
    end

endmodule
